// File: rtl/bs_mul_seq.sv
// ---------------------------------------------------------------------------
// bs_mul_seq : binary-serial multiplier sequencer for one PE of the 16-bit
// binary-serial systolic array.
//
// Latches one signed activation/weight pair. It then emits one partial
// product per cycle, walking the activation bits MSB-first. It also drives
// the accumulator controls so that the accumulator recurrence
//    sum <= prod + (sum << 1)
// builds wght*ifm. The final mac_done cycle then adds the incoming partial
// sum (sum_i + sum).
//
// Handshake: a pair is transferred on a rising edge where in_vld && in_rdy.
// in_vld may rise at any time, and the source must hold ifm/wght stable
// until the transfer. in_rdy never depends on in_vld.
//
// Optional feature (macro BS_ZERO_SKIP_EN): when the latched activation is
// zero, the sequencer goes CLR -> DONE directly and skips the serial phase.
//
// Parameters
//    IWIDTH  activation width, which is also the number of serial cycles
//    WWIDTH  weight width
//    OWIDTH  product width. It must satisfy OWIDTH >= IWIDTH + WWIDTH.
//
// Ports
//    clk, rst_n   clock, asynchronous active-low reset
//    en           global advance. Low freezes the sequencer and gates the
//                 control outputs.
//    clr          synchronous abort back to IDLE
//    in_vld       ifm/wght valid
//    in_rdy       a pair can be accepted this cycle
//    ifm, wght    signed activation / weight
//    prod         signed partial product for the accumulator
//    acc_en       accumulator enable
//    acc_clr      accumulator synchronous clear
//    mac_done     accumulator final-add select
//    sum_vld      accumulator result valid (one-cycle pulse)
//    state_dbg    current FSM state (IDLE=0, CLR=1, SER=2, DONE=3)
//    cnt_dbg      current serial bit index
// ---------------------------------------------------------------------------
module bs_mul_seq #(
   parameter int IWIDTH = 16,
   parameter int WWIDTH = 16,
   parameter int OWIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [IWIDTH-1:0]         ifm,
   input  logic [WWIDTH-1:0]         wght,
   output logic [OWIDTH-1:0]         prod,
   output logic                      acc_en,
   output logic                      acc_clr,
   output logic                      mac_done,
   output logic                      sum_vld,
   output logic [1:0]                state_dbg,
   output logic [$clog2(IWIDTH)-1:0] cnt_dbg
);

   localparam int CW = $clog2(IWIDTH);

   // Index of the activation MSB. Its term carries negative weight in
   // two's complement.
   localparam logic [CW-1:0] CNT_MSB = CW'(IWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      SER  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [IWIDTH-1:0] ifm_r;
   logic [WWIDTH-1:0] wght_r;
   logic              accept;
   logic [OWIDTH-1:0] w_ext;

   // A new pair can be taken while idle, or in the DONE cycle of the
   // previous pair. The DONE case gives back-to-back operation with no
   // bubble.
   assign in_rdy = en && !clr && (state == IDLE || state == DONE);
   assign accept = in_vld && in_rdy;

   // ------------------------------------------------------------------
   // Sequencer state. Everything holds while en is low, except sum_vld,
   // which is a pulse and therefore drops.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ifm_r   <= '0;
         wght_r  <= '0;
         sum_vld <= 1'b0;
      end else if (clr) begin
         // Abort wins over en and over any pending accept. The
         // interrupted MAC never produces sum_vld.
         state   <= IDLE;
         cnt     <= '0;
         sum_vld <= 1'b0;
      end else begin
         // The accumulator holds sum_i + sum right after an enabled
         // DONE cycle.
         sum_vld <= en && (state == DONE);
         if (en) begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     ifm_r  <= ifm;
                     wght_r <= wght;
                     cnt    <= CNT_MSB;
                     state  <= CLR;
                  end
               end
               CLR: begin
`ifdef BS_ZERO_SKIP_EN
                  // A zero activation contributes nothing, and the cleared
                  // accumulator already holds the right partial value.
                  if (ifm_r == '0) begin
                     state <= DONE;
                  end else begin
                     state <= SER;
                  end
`else
                  state <= SER;
`endif
               end
               SER: begin
                  if (cnt == '0) begin
                     state <= DONE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               DONE: begin
                  if (accept) begin
                     ifm_r  <= ifm;
                     wght_r <= wght;
                     cnt    <= CNT_MSB;
                     state  <= CLR;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Partial product decode. It is not gated by en, so that a stalled
   // cycle still shows the pending term.
   // ------------------------------------------------------------------
   always_comb begin
      w_ext = {{(OWIDTH-WWIDTH){wght_r[WWIDTH-1]}}, wght_r};
      prod  = '0;
      if (state == SER && ifm_r[cnt]) begin
         // The negation is done at full OWIDTH width, so the most
         // negative weight negates exactly.
         if (cnt == CNT_MSB) begin
            prod = -w_ext;
         end else begin
            prod = w_ext;
         end
      end
   end

   // ------------------------------------------------------------------
   // Accumulator controls. These are Moore outputs gated by en.
   // ------------------------------------------------------------------
   assign acc_clr   = en && (state == CLR);
   assign acc_en    = en && (state == SER || state == DONE);
   assign mac_done  = en && (state == DONE);
   assign state_dbg = state;
   assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_bs_mul_seq.sv
module tb_bs_mul_seq;

   localparam int IW = 16;
   localparam int WW = 16;
   localparam int OW = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CLR  = 2'd1;
   localparam logic [1:0] S_SER  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef BS_ZERO_SKIP_EN
   localparam int ZS_LAT = 3;
`else
   localparam int ZS_LAT = 19;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          clr;
   logic          in_vld;
   logic          in_rdy;
   logic [IW-1:0] ifm;
   logic [WW-1:0] wght;
   logic [OW-1:0] prod;
   logic          acc_en;
   logic          acc_clr;
   logic          mac_done;
   logic          sum_vld;
   logic [1:0]    state_dbg;
   logic [3:0]    cnt_dbg;

   always #5 clk = ~clk;

   // edge_n counts rising edges. When sampled at a falling edge,
   // edge_n + 1 is the edge that ends the current cycle.
   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   bs_mul_seq #(.IWIDTH(IW), .WWIDTH(WW), .OWIDTH(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .ifm       (ifm),
      .wght      (wght),
      .prod      (prod),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .mac_done  (mac_done),
      .sum_vld   (sum_vld),
      .state_dbg (state_dbg),
      .cnt_dbg   (cnt_dbg)
   );

   // ---------------- accumulator reference model ----------------
   logic [31:0] acc_sum;
   logic [31:0] sum_i;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         acc_sum <= '0;
      else if (acc_clr)   acc_sum <= '0;
      else if (acc_en) begin
         if (mac_done)    acc_sum <= sum_i + acc_sum;
         else             acc_sum <= prod + (acc_sum << 1);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] exp_cyc_q[$];
   logic [31:0] mon_e;
   logic [31:0] mon_c;

   always @(negedge clk) begin
      if (rst_n && sum_vld) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sum_vld: got sum 0x%08h, expected no result (t=%0t)", acc_sum, $time);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("sum", acc_sum, mon_e);
            check("sum_vld_cycle", 32'(edge_n + 1), mon_c);
         end
      end
   end

   // ---------------- driver tasks (entered and left at a falling edge) ----------------
   task automatic send(input logic [IW-1:0] a, input logic [WW-1:0] b, input logic [31:0] e,
                       input int lat, input bit push, output int t0);
      ifm    = a;
      wght   = b;
      in_vld = 1'b1;
      t0     = -1;
      for (int k = 0; k < 60 && t0 < 0; k++) begin
         #1;
         if (in_rdy) begin
            t0 = edge_n + 1;
            if (push) begin
               exp_q.push_back(e);
               exp_cyc_q.push_back(32'(t0 + lat));
            end
         end
         @(negedge clk);
      end
      in_vld = 1'b0;
      if (t0 < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept, expected accept within 60 cycles");
      end
   endtask

   task automatic wait_ser_cnt(input logic [3:0] c);
      bit found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (state_dbg == S_SER && cnt_dbg == c) found = 1;
         else @(negedge clk);
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL ser_cnt_timeout: got no SER cnt=%0d, expected it within 40 cycles", c);
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   int t0;
   int t1;
   int t2;

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      clr    = 1'b0;
      in_vld = 1'b0;
      ifm    = '0;
      wght   = '0;
      sum_i  = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_rdy_en0", {31'd0, in_rdy}, 32'd0);
      en = 1'b1;
      #1;
      check("rst_in_rdy_en1", {31'd0, in_rdy}, 32'd1);
      check("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
      check("rst_cnt", {28'd0, cnt_dbg}, 32'd0);
      check("rst_prod", prod, 32'd0);
      check("rst_ctrl", {28'd0, acc_en, acc_clr, mac_done, sum_vld}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. basic multiply: 3 * 5
      sum_i = 32'd0;
      send(16'd3, 16'd5, 32'd15, 19, 1'b1, t0);
      check("t1_clr_state", {30'd0, state_dbg}, {30'd0, S_CLR});
      check("t1_acc_clr", {31'd0, acc_clr}, 32'd1);
      check("t1_acc_en_in_clr", {31'd0, acc_en}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("t1_prod", prod, (i >= 14) ? 32'd5 : 32'd0);
         check("t1_acc_en", {31'd0, acc_en}, 32'd1);
      end
      @(negedge clk);
      check("t1_mac_done", {31'd0, mac_done}, 32'd1);
      check("t1_mac_done_cycle", 32'(edge_n + 1), 32'(t0 + 18));
      wait_drain();

      // 2. signed extremes
      send(16'h8000, 16'h0001, 32'hFFFF_8000, 19, 1'b1, t0);
      @(negedge clk);
      check("t2_first_ser_prod", prod, 32'hFFFF_FFFF);
      wait_drain();
      send(16'hFFFF, 16'h8000, 32'h0000_8000, 19, 1'b1, t0);
      wait_drain();
      send(16'h8000, 16'h8000, 32'h4000_0000, 19, 1'b1, t0);
      wait_drain();

      // 3. back-to-back with in_vld held: (2,7) and (-4,9), sum_i = 100
      sum_i = 32'd100;
      send(16'd2, 16'd7, 32'd114, 19, 1'b1, t1);
      send(16'hFFFC, 16'd9, 32'd64, 19, 1'b1, t2);
      check("t3_accept_spacing", 32'(t2 - t1), 32'd18);
      wait_drain();

      // 4. five-cycle stall at SER cnt=7: 1234 * -3
      sum_i = 32'd0;
      send(16'd1234, 16'hFFFD, 32'hFFFF_F18A, 24, 1'b1, t0);
      wait_ser_cnt(4'd7);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t4_stall_acc_en", {31'd0, acc_en}, 32'd0);
         check("t4_stall_cnt", {28'd0, cnt_dbg}, 32'd7);
         check("t4_stall_in_rdy", {31'd0, in_rdy}, 32'd0);
         @(negedge clk);
      end
      en = 1'b1;
      wait_drain();

      // 5a. abort with clr at SER cnt=4
      send(16'h1357, 16'd11, 32'd0, 0, 1'b0, t0);
      wait_ser_cnt(4'd4);
      clr = 1'b1;
      #1;
      check("t5_clr_in_rdy", {31'd0, in_rdy}, 32'd0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("t5_clr_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
      check("t5_clr_in_rdy_after", {31'd0, in_rdy}, 32'd1);
      check("t5_clr_cnt", {28'd0, cnt_dbg}, 32'd0);
      repeat (25) @(negedge clk);

      // 5b. reset in the middle of SER
      send(16'h1111, 16'd3, 32'd0, 0, 1'b0, t0);
      wait_ser_cnt(4'd9);
      rst_n = 1'b0;
      #1;
      check("t5_rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
      check("t5_rst_cnt", {28'd0, cnt_dbg}, 32'd0);
      check("t5_rst_prod", prod, 32'd0);
      check("t5_rst_ctrl", {28'd0, acc_en, acc_clr, mac_done, sum_vld}, 32'd0);
      check("t5_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);

      // 6. zero activation: 0 * 77 + 9
      sum_i = 32'd9;
      send(16'd0, 16'd77, 32'd9, ZS_LAT, 1'b1, t0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
